// File: rtl/sdram_aref_pkg.sv
//==============================================================================
// Module   : sdram_aref_pkg
// Desc     : Shared SDRAM controller constants: command encodings, A10
//            precharge-all address and default refresh timing.
// Revision : 1.0
//==============================================================================
`default_nettype none

package sdram_aref_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;

    localparam logic [12:0] c_a10_pre_all = 13'h0400;

    localparam int unsigned c_t_rp_default  = 2;
    localparam int unsigned c_t_rfc_default = 7;

    // Wait counter reload value for a T_x-cycle command gap
    function automatic logic [3:0] wait_load(input int unsigned t);
        return 4'(t - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_aref.sv
//==============================================================================
// Module   : sdram_aref
// Desc     : Auto-refresh sequencer: queues refresh ticks, wins the command
//            bus, issues PRECHARGE-ALL / AUTO REFRESH. Optional macro
//            SDRAM_AREF_BURST_EN chains queued refreshes under one grant.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sdram_aref
    import sdram_aref_pkg::*;
#(
    parameter int unsigned T_RP  = c_t_rp_default,
    parameter int unsigned T_RFC = c_t_rfc_default
) (
    input  logic        clk,
    input  logic        soft_rst_n,
    input  logic        init_done,
    input  logic        rt_flag,
    output logic        rt_en,
    input  logic        ref_grant,
    output logic        ref_req,
    output logic        ref_done,
    output logic        ref_overrun,
    output logic [3:0]  sdr_cmd,
    output logic [12:0] sdr_addr,
    output logic [1:0]  sdr_ba
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_PRE  = 3'd2,
        S_TRP  = 3'd3,
        S_AREF = 3'd4,
        S_TRFC = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [3:0] c_trp_load  = wait_load(T_RP);
    localparam logic [3:0] c_trfc_load = wait_load(T_RFC);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait;
    logic [2:0]  r_pend;
    logic [2:0]  w_pend_next;
    logic        w_pend_dec;
    logic        w_burst_more;
    logic        w_burst_keep;

    logic        r_rt_en;
    logic        r_ref_req;
    logic        r_ref_done;
    logic        r_ref_overrun;
    logic [3:0]  r_sdr_cmd;
    logic [12:0] r_sdr_addr;

    logic        w_req_next;
    logic [3:0]  w_cmd_next;
    logic [12:0] w_addr_next;

    // r_pend is already decremented while in DONE, so nonzero means more work
`ifdef SDRAM_AREF_BURST_EN
    assign w_burst_more = (r_pend != 3'd0);
    assign w_burst_keep = (w_pend_next != 3'd0);
`else
    assign w_burst_more = 1'b0;
    assign w_burst_keep = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!soft_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_pend != 3'd0) && init_done) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!init_done) begin
                    w_state_next = S_IDLE;
                end else if (ref_grant) begin
                    w_state_next = S_PRE;
                end
            end
            S_PRE:  w_state_next = (T_RP == 1) ? S_AREF : S_TRP;
            S_TRP: begin
                if (r_wait <= 4'd1) begin
                    w_state_next = S_AREF;
                end
            end
            S_AREF: w_state_next = (T_RFC == 1) ? S_DONE : S_TRFC;
            S_TRFC: begin
                if (r_wait <= 4'd1) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = w_burst_more ? S_AREF : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        w_req_next  = 1'b0;
        w_cmd_next  = CMD_NOP;
        w_addr_next = 13'h0000;
        case (w_state_next)
            S_REQ, S_TRP, S_TRFC: w_req_next = 1'b1;
            S_PRE: begin
                w_req_next  = 1'b1;
                w_cmd_next  = CMD_PRE;
                w_addr_next = c_a10_pre_all;
            end
            S_AREF: begin
                w_req_next = 1'b1;
                w_cmd_next = CMD_AREF;
            end
            S_DONE:  w_req_next = w_burst_keep;
            default: w_req_next = 1'b0;
        endcase
    end

    assign w_pend_dec = (w_state_next == S_DONE);

    always_comb begin
        w_pend_next = r_pend;
        if (rt_flag && !w_pend_dec) begin
            if (r_pend != 3'd7) begin
                w_pend_next = r_pend + 3'd1;
            end
        end else if (!rt_flag && w_pend_dec) begin
            w_pend_next = r_pend - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!soft_rst_n) begin
            r_wait <= 4'd0;
        end else if ((w_state_next == S_TRP) && (r_state != S_TRP)) begin
            r_wait <= c_trp_load;
        end else if ((w_state_next == S_TRFC) && (r_state != S_TRFC)) begin
            r_wait <= c_trfc_load;
        end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!soft_rst_n) begin
            r_pend        <= 3'd0;
            r_rt_en       <= 1'b0;
            r_ref_req     <= 1'b0;
            r_ref_done    <= 1'b0;
            r_ref_overrun <= 1'b0;
            r_sdr_cmd     <= CMD_NOP;
            r_sdr_addr    <= 13'h0000;
        end else begin
            r_pend     <= w_pend_next;
            r_rt_en    <= init_done;
            r_ref_req  <= w_req_next;
            r_ref_done <= w_pend_dec;
            r_sdr_cmd  <= w_cmd_next;
            r_sdr_addr <= w_addr_next;
            if (rt_flag && (r_pend == 3'd7)) begin
                r_ref_overrun <= 1'b1;
            end
        end
    end

    assign rt_en       = r_rt_en;
    assign ref_req     = r_ref_req;
    assign ref_done    = r_ref_done;
    assign ref_overrun = r_ref_overrun;
    assign sdr_cmd     = r_sdr_cmd;
    assign sdr_addr    = r_sdr_addr;
    assign sdr_ba      = 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_sdram_aref.sv
//==============================================================================
// Module   : tb_sdram_aref
// Desc     : Scoreboard bench for sdram_aref (default build, T_RP=2, T_RFC=7).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_sdram_aref;

    localparam int TRP  = 2;
    localparam int TRFC = 7;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam int EV_PRE  = 1;
    localparam int EV_AREF = 2;
    localparam int EV_DONE = 3;
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_BUSY = 2;

    logic        clk = 1'b0;
    logic        soft_rst_n;
    logic        init_done;
    logic        rt_flag;
    logic        ref_grant;
    logic        rt_en;
    logic        ref_req;
    logic        ref_done;
    logic        ref_overrun;
    logic [3:0]  sdr_cmd;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;

    sdram_aref #(.T_RP(TRP), .T_RFC(TRFC)) dut (
        .clk         (clk),
        .soft_rst_n  (soft_rst_n),
        .init_done   (init_done),
        .rt_flag     (rt_flag),
        .rt_en       (rt_en),
        .ref_grant   (ref_grant),
        .ref_req     (ref_req),
        .ref_done    (ref_done),
        .ref_overrun (ref_overrun),
        .sdr_cmd     (sdr_cmd),
        .sdr_addr    (sdr_addr),
        .sdr_ba      (sdr_ba)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    // Reference model: pending tick count plus a timestamped bus ownership
    int  m_pend = 0;
    int  m_mode = M_IDLE;
    int  m_done_cyc = 0;
    bit  m_ovr = 1'b0;
    bit  exp_req = 1'b0, exp_ovr = 1'b0, exp_rt_en = 1'b0;
    bit  nxt_req = 1'b0, nxt_ovr = 1'b0, nxt_rt_en = 1'b0;

    // Consumes the inputs of the current cycle and predicts the next cycle
    task automatic model_step();
        int c = cyc;
        int pend_old = m_pend;
        bit dec;
        if (!soft_rst_n) begin
            m_pend = 0;
            m_mode = M_IDLE;
            m_ovr  = 1'b0;
            exp_q.delete();
            nxt_req   = 1'b0;
            nxt_ovr   = 1'b0;
            nxt_rt_en = 1'b0;
            return;
        end
        dec = (m_mode == M_BUSY) && (c + 1 == m_done_cyc);
        case (m_mode)
            M_IDLE: if (pend_old != 0 && init_done) m_mode = M_REQ;
            M_REQ: begin
                if (!init_done) begin
                    m_mode = M_IDLE;
                end else if (ref_grant) begin
                    m_mode     = M_BUSY;
                    m_done_cyc = c + 1 + TRP + TRFC;
                    exp_q.push_back('{kind: EV_PRE,  cyc: c + 1});
                    exp_q.push_back('{kind: EV_AREF, cyc: c + 1 + TRP});
                    exp_q.push_back('{kind: EV_DONE, cyc: m_done_cyc});
                end
            end
            default: if (c == m_done_cyc) m_mode = M_IDLE;
        endcase
        if (rt_flag && pend_old == 7) m_ovr = 1'b1;
        if (rt_flag && !dec) begin
            if (m_pend < 7) m_pend = m_pend + 1;
        end else if (!rt_flag && dec) begin
            m_pend = m_pend - 1;
        end
        nxt_req   = (m_mode == M_REQ) || (m_mode == M_BUSY && c + 1 != m_done_cyc);
        nxt_ovr   = m_ovr;
        nxt_rt_en = init_done;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        cyc       = cyc + 1;
        exp_req   = nxt_req;
        exp_ovr   = nxt_ovr;
        exp_rt_en = nxt_rt_en;
        mon_en    = 1'b1;
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input bit req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, req);
        end
    endtask

    task automatic got_event(input int kind);
        ev_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_event cyc=%0d got_kind=%0d expected=none", cyc, kind);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL event got kind=%0d at cyc=%0d expected kind=%0d at cyc=%0d",
                         kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL missed_event cyc=%0d got=nothing expected kind=%0d at cyc=%0d",
                         cyc, exp_q[0].kind, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            check_bit("ref_req", ref_req, exp_req);
            check_bit("ref_overrun", ref_overrun, exp_ovr);
            check_bit("rt_en", rt_en, exp_rt_en);
            checks = checks + 1;
            if (!((sdr_cmd === NOP) || (sdr_cmd === PRE) || (sdr_cmd === AREF)) ||
                (sdr_ba !== 2'b00) ||
                (sdr_addr !== ((sdr_cmd === PRE) ? 13'h0400 : 13'h0000))) begin
                errors = errors + 1;
                $display("FAIL bus cyc=%0d got cmd=%b addr=%h ba=%b expected legal cmd, A10 only on PRE, ba=00",
                         cyc, sdr_cmd, sdr_addr, sdr_ba);
            end
            if (sdr_cmd === PRE)  got_event(EV_PRE);
            if (sdr_cmd === AREF) got_event(EV_AREF);
            if (ref_done !== 1'b0) got_event(EV_DONE);
        end
    end

    initial begin
        soft_rst_n = 1'b0;
        init_done  = 1'b0;
        rt_flag    = 1'b0;
        ref_grant  = 1'b0;
        repeat (3) step();
        soft_rst_n = 1'b1;
        repeat (3) step();
        init_done = 1'b1;
        repeat (1000) step();

        // Single tick, grant tied high
        ref_grant = 1'b1;
        rt_flag = 1'b1; step(); rt_flag = 1'b0;
        repeat (20) step();

        // Grant held off 20 cycles, then dropped mid-sequence
        ref_grant = 1'b0;
        rt_flag = 1'b1; step(); rt_flag = 1'b0;
        repeat (20) step();
        ref_grant = 1'b1;
        repeat (4) step();
        ref_grant = 1'b0;
        repeat (14) step();

        // Three ticks accumulate while grant is low
        for (int i = 0; i < 3; i++) begin
            rt_flag = 1'b1; step(); rt_flag = 1'b0; step();
        end
        repeat (10) step();
        ref_grant = 1'b1;
        repeat (50) step();

        // Eight ticks saturate the counter and set the sticky overrun
        ref_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rt_flag = 1'b1; step(); rt_flag = 1'b0; step();
        end
        repeat (5) step();
        ref_grant = 1'b1;
        repeat (110) step();

        // init_done falls while requesting
        ref_grant = 1'b0;
        rt_flag = 1'b1; step(); rt_flag = 1'b0;
        repeat (4) step();
        init_done = 1'b0;
        repeat (6) step();
        init_done = 1'b1;
        ref_grant = 1'b1;
        repeat (20) step();

        // Reset pulse in the middle of the tRFC wait
        rt_flag = 1'b1; step(); rt_flag = 1'b0;
        repeat (7) step();
        soft_rst_n = 1'b0; step(); soft_rst_n = 1'b1;
        repeat (20) step();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rt_flag = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) ref_grant = 1'($urandom_range(0, 1));
            init_done  = ($urandom_range(0, 63) != 0);
            soft_rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rt_flag = 1'b0; ref_grant = 1'b1; init_done = 1'b1; soft_rst_n = 1'b1;
        repeat (120) step();

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got=%0d outstanding events expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
